uart_tx_fifo: RTL and testbench

Buffered 8-bit UART transmitter: accepts bytes over a valid/ready handshake into an internal FIFO and serialises them onto `txd` as 8-bit, LSB-first frames with optional parity and 1 or 2 stop bits. It is the transmit end of the board-level UART link to the soft-processor `uart_0` core. It drives that core's `rxd` pin and replaces hand-timed transmit logic in fabric-side UART control.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Cycles per bit for the common board clock / baud combinations.
  localparam int unsigned BAUD_100M_9600   = 10416;
  localparam int unsigned BAUD_125M_115200 = 1085;

  localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered level; head word is read combinationally.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8E1/8O2-style UART transmitter: FIFO in, LSB-first serial frames out.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_SET_COUNTER = BAUD_125M_115200,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned PARITY_EN        = 0,
  parameter int unsigned PARITY_ODD       = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CW = $clog2(BAUD_SET_COUNTER);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_SET_COUNTER - 1);
  localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              txd_q, txd_d;

  logic              bit_end, stop_last, load;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready  = (fifo_level < LW'(FIFO_DEPTH));
  assign busy      = (state_q != ST_IDLE) || (fifo_level != '0);
  assign txd       = txd_q;
  assign bit_end   = (cnt_q == CNT_MAX);
  assign stop_last = (STOP_BITS == 2) ? stop_idx_q : 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    load       = 1'b0;
    fifo_pop   = 1'b0;
    txd_d      = 1'b1;

    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          if (bit_idx_q == 3'd7) begin
            state_d    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_idx_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_last) begin
            // Chain straight into the next start bit to keep frames gap-free.
            if (!fifo_empty) begin
              load    = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      shreg_d  = fifo_head;
      par_d    = (^fifo_head) ^ PAR_ODD_BIT;
    end

    // txd is registered, so it is driven from the state being entered.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover framing, parity, depth and long baud.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0] tx_data_a, tx_data_p0, tx_data_p1, tx_data_l;
  logic       tx_valid_a, tx_valid_p0, tx_valid_p1, tx_valid_l;
  logic       tx_ready_a, tx_ready_p0, tx_ready_p1, tx_ready_l;
  logic       txd_a, txd_p0, txd_p1, txd_l;
  logic       busy_a, busy_p0, busy_p1, busy_l;
  logic [4:0] level_a, level_p0, level_p1, level_l;

  int vec  = 0;
  int miss = 0;

  uart_tx_fifo #(.BAUD_SET_COUNTER(4), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .txd(txd_a), .busy(busy_a), .fifo_level(level_a));

  uart_tx_fifo #(.BAUD_SET_COUNTER(4), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p0 (
    .clk(clk), .rst(rst), .tx_data(tx_data_p0), .tx_valid(tx_valid_p0), .tx_ready(tx_ready_p0),
    .txd(txd_p0), .busy(busy_p0), .fifo_level(level_p0));

  uart_tx_fifo #(.BAUD_SET_COUNTER(4), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_p1 (
    .clk(clk), .rst(rst), .tx_data(tx_data_p1), .tx_valid(tx_valid_p1), .tx_ready(tx_ready_p1),
    .txd(txd_p1), .busy(busy_p1), .fifo_level(level_p1));

  uart_tx_fifo #(.BAUD_SET_COUNTER(1085), .FIFO_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_l (
    .clk(clk), .rst(rst), .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready_l),
    .txd(txd_l), .busy(busy_l), .fifo_level(level_l));

  // Expected line level i cycles after the start-bit fall, for 4 cycles per bit.
  function automatic logic exp_bit(input logic [7:0] b, input bit par_en, input bit odd, input int i);
    int p;
    p = i / 4;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (p == 9 && par_en) return (^b) ^ odd;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tx_valid_a = 1'b0; tx_valid_p0 = 1'b0; tx_valid_p1 = 1'b0; tx_valid_l = 1'b0;
    tx_data_a = '0; tx_data_p0 = '0; tx_data_p1 = '0; tx_data_l = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    vec++; if (txd_a !== 1'b1)      begin miss++; $display("FAIL reset_txd: got %b expected 1", txd_a); end
    vec++; if (level_a !== 5'd0)    begin miss++; $display("FAIL reset_level: got %0d expected 0", level_a); end
    vec++; if (tx_ready_a !== 1'b1) begin miss++; $display("FAIL reset_ready: got %b expected 1", tx_ready_a); end
    vec++; if (busy_a !== 1'b0)     begin miss++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    vec++; if ({txd_p0, txd_p1, txd_l} !== 3'b111) begin
      miss++; $display("FAIL reset_txd_others: got %b expected 111", {txd_p0, txd_p1, txd_l});
    end
  endtask

  task automatic test_basic_frame;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    @(negedge clk);
    tx_data_a = 8'hA5; tx_valid_a = 1'b1;
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    vec++; if (level_a !== 5'd1) begin miss++; $display("FAIL basic_level: got %0d expected 1", level_a); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      vec++;
      if (txd_a !== frame[i/4]) begin
        miss++; $display("FAIL basic_txd[%0d]: got %b expected %b", i, txd_a, frame[i/4]);
      end
      if (i == 20) begin
        vec++; if (busy_a !== 1'b1) begin miss++; $display("FAIL basic_busy_mid: got %b expected 1", busy_a); end
      end
    end
    @(posedge clk); #1;
    vec++; if (txd_a !== 1'b1)  begin miss++; $display("FAIL basic_idle_txd: got %b expected 1", txd_a); end
    vec++; if (busy_a !== 1'b0) begin miss++; $display("FAIL basic_end_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_parity;
    logic e0, e1;
    @(negedge clk);
    tx_data_p0 = 8'hA5; tx_valid_p0 = 1'b1;
    tx_data_p1 = 8'hA5; tx_valid_p1 = 1'b1;
    @(posedge clk); #1;
    tx_valid_p0 = 1'b0; tx_valid_p1 = 1'b0;
    for (int i = 0; i <= 48; i++) begin
      @(posedge clk); #1;
      e0 = (i < 48) ? exp_bit(8'hA5, 1'b1, 1'b0, i) : 1'b1;
      e1 = (i < 44) ? exp_bit(8'hA5, 1'b1, 1'b1, i) : 1'b1;
      vec++; if (txd_p0 !== e0) begin miss++; $display("FAIL even2_txd[%0d]: got %b expected %b", i, txd_p0, e0); end
      vec++; if (txd_p1 !== e1) begin miss++; $display("FAIL odd1_txd[%0d]: got %b expected %b", i, txd_p1, e1); end
      if (i == 38) begin
        vec++; if (txd_p0 !== 1'b0) begin miss++; $display("FAIL even_parity_bit: got %b expected 0", txd_p0); end
        vec++; if (txd_p1 !== 1'b1) begin miss++; $display("FAIL odd_parity_bit: got %b expected 1", txd_p1); end
      end
      if (i == 47) begin
        vec++; if (busy_p0 !== 1'b1) begin miss++; $display("FAIL even2_busy_last_stop: got %b expected 1", busy_p0); end
      end
      if (i == 44) begin
        vec++; if (busy_p1 !== 1'b0) begin miss++; $display("FAIL odd1_end_busy: got %b expected 0", busy_p1); end
      end
      if (i == 48) begin
        vec++; if (busy_p0 !== 1'b0) begin miss++; $display("FAIL even2_end_busy: got %b expected 0", busy_p0); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int idx, held, e;
    logic rdy, exp;
    idx = 0; held = 0; e = 0;
    fork
      begin
        while (idx < 18 && e < 200) begin
          @(negedge clk);
          tx_valid_a = 1'b1; tx_data_a = 8'(idx); rdy = tx_ready_a;
          @(posedge clk); #1;
          if (rdy) idx++; else held++;
          if (idx == 18) tx_valid_a = 1'b0;
          if (e == 16) begin
            vec++; if (level_a !== 5'd16) begin miss++; $display("FAIL burst_full_level: got %0d expected 16", level_a); end
            vec++; if (tx_ready_a !== 1'b0) begin miss++; $display("FAIL burst_full_ready: got %b expected 0", tx_ready_a); end
          end
          e++;
        end
        tx_valid_a = 1'b0;
        vec++; if (held !== 25) begin miss++; $display("FAIL burst_held_cycles: got %0d expected 25", held); end
      end
      begin
        @(posedge clk);
        for (int i = 0; i < 720; i++) begin
          @(posedge clk); #1;
          exp = exp_bit(8'(i / 40), 1'b0, 1'b0, i % 40);
          vec++; if (txd_a !== exp) begin miss++; $display("FAIL burst_txd[%0d]: got %b expected %b", i, txd_a, exp); end
        end
        @(posedge clk); #1;
        vec++; if (txd_a !== 1'b1)  begin miss++; $display("FAIL burst_idle_txd: got %b expected 1", txd_a); end
        vec++; if (busy_a !== 1'b0) begin miss++; $display("FAIL burst_end_busy: got %b expected 0", busy_a); end
      end
    join
  endtask

  task automatic test_push_pop;
    logic [7:0] bytes [3];
    logic exp;
    bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h81;
    for (int e = 0; e <= 121; e++) begin
      @(negedge clk);
      tx_valid_a = (e == 0 || e == 1 || e == 41);
      tx_data_a  = (e == 0) ? bytes[0] : (e == 1) ? bytes[1] : bytes[2];
      @(posedge clk); #1;
      tx_valid_a = 1'b0;
      if (e == 1 || e == 41) begin
        vec++; if (level_a !== 5'd1) begin miss++; $display("FAIL pushpop_level_e%0d: got %0d expected 1", e, level_a); end
      end
      if (e >= 1 && e <= 120) begin
        exp = exp_bit(bytes[(e-1)/40], 1'b0, 1'b0, (e-1) % 40);
        vec++; if (txd_a !== exp) begin miss++; $display("FAIL pushpop_txd[%0d]: got %b expected %b", e, txd_a, exp); end
      end
      if (e == 121) begin
        vec++; if ({txd_a, busy_a} !== 2'b10) begin
          miss++; $display("FAIL pushpop_end: got txd/busy %b expected 10", {txd_a, busy_a});
        end
        vec++; if (level_a !== 5'd0) begin miss++; $display("FAIL pushpop_end_level: got %0d expected 0", level_a); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int lows, busies;
    for (int e = 0; e <= 19; e++) begin
      @(negedge clk);
      tx_valid_a = (e < 4);
      tx_data_a  = 8'(8'h11 * (e + 1));
      @(posedge clk); #1;
      tx_valid_a = 1'b0;
    end
    vec++; if (level_a !== 5'd3) begin miss++; $display("FAIL rstmid_level_before: got %0d expected 3", level_a); end
    vec++; if (busy_a !== 1'b1)  begin miss++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_a); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    vec++; if (txd_a !== 1'b1)      begin miss++; $display("FAIL rstmid_txd: got %b expected 1", txd_a); end
    vec++; if (level_a !== 5'd0)    begin miss++; $display("FAIL rstmid_level: got %0d expected 0", level_a); end
    vec++; if (busy_a !== 1'b0)     begin miss++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
    vec++; if (tx_ready_a !== 1'b1) begin miss++; $display("FAIL rstmid_ready: got %b expected 1", tx_ready_a); end
    @(negedge clk);
    rst = 1'b0;
    lows = 0; busies = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (txd_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) busies++;
    end
    vec++; if (lows !== 0)   begin miss++; $display("FAIL rstmid_no_start: got %0d low cycles expected 0", lows); end
    vec++; if (busies !== 0) begin miss++; $display("FAIL rstmid_idle: got %0d busy cycles expected 0", busies); end
  endtask

  task automatic test_long_baud;
    logic [9:0] lf;
    int n, m, p;
    lf = {1'b1, 8'h55, 1'b0};
    n = 0;
    @(negedge clk);
    tx_data_l = 8'h55; tx_valid_l = 1'b1;
    @(posedge clk); #1;
    tx_valid_l = 1'b0;
    for (int k = 1; k <= 20000; k++) begin
      @(posedge clk); #1;
      n = k;
      m = k - 1;
      if (k == 1) begin
        vec++; if (txd_l !== 1'b0) begin miss++; $display("FAIL long_fall: got %b expected 0", txd_l); end
      end
      p = m / 1085;
      if (m % 1085 == 542 && p <= 9) begin
        vec++; if (txd_l !== lf[p]) begin miss++; $display("FAIL long_bit%0d: got %b expected %b", p, txd_l, lf[p]); end
      end
      if (busy_l === 1'b0) break;
    end
    vec++; if (n - 1 !== 10850) begin miss++; $display("FAIL long_frame_cycles: got %0d expected 10850", n - 1); end
    vec++; if (txd_l !== 1'b1)  begin miss++; $display("FAIL long_idle_txd: got %b expected 1", txd_l); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_push_pop();
    test_reset_mid_frame();
    test_long_baud();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
